// File: rtl/zacore_common.sv
// Shared types for the zacore front end: fetch/decode handoff record and fetch FSM states.
package zacore_common;

  typedef logic [31:0] w_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic  valid;
    w_t    pc;
    inst_t inst;
  } fetch_decode_if_t;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  localparam int unsigned FETCH_QUEUE_DEPTH = 2;
  localparam w_t          PC_STEP           = 32'd4;

  // Word-align an address; redirect targets may carry stray low bits.
  function automatic w_t align_pc(input w_t pc);
    return pc & ~w_t'(3);
  endfunction

endpackage

// File: rtl/zacore_fetch_queue.sv
// Two-entry in-order buffer of fetched {pc, inst}; head is read straight from storage flops.
module zacore_fetch_queue
  import zacore_common::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  w_t          i_push_pc,
  input  inst_t       i_push_inst,
  input  logic        i_pop,
  input  logic        i_flush,
  output w_t          o_head_pc,
  output inst_t       o_head_inst,
  output logic [1:0]  o_count
);

  w_t         r_pc   [FETCH_QUEUE_DEPTH];
  inst_t      r_inst [FETCH_QUEUE_DEPTH];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2);
  assign w_do_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < FETCH_QUEUE_DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (w_do_push && !i_flush) begin
      r_pc[r_wr_ptr]   <= i_push_pc;
      r_inst[r_wr_ptr] <= i_push_inst;
    end
  end

  assign o_head_pc   = r_pc[r_rd_ptr];
  assign o_head_inst = r_inst[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/zacore_fetch.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer to decode, redirect/flush support.
module zacore_fetch
  import zacore_common::*;
#(
  parameter w_t RESET_PC = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req_valid,
  input  logic             i_imem_req_ready,
  output logic [31:0]      o_imem_req_addr,
  input  logic             i_imem_rsp_valid,
  input  logic [31:0]      i_imem_rsp_data,
  output fetch_decode_if_t o_fetch_decode_if,
  input  logic             i_stall,
  input  logic             i_redirect_valid,
  input  logic [31:0]      i_redirect_pc
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  w_t           r_pc;
  w_t           w_pc_nxt;
  w_t           r_req_pc;
  w_t           w_req_pc_nxt;
  logic         r_req_valid;
  logic         w_req_valid_nxt;

  logic         w_hs;
  logic         w_push;
  logic         w_pop;
  logic         w_outstanding;
  logic [1:0]   w_queue_count;
  logic [1:0]   w_count_nxt;
  logic         w_dec_valid;
  w_t           w_head_pc;
  inst_t        w_head_inst;

  // req_valid is a flop, so it only ever rises while the FSM sits in REQ.
  assign w_hs        = r_req_valid && i_imem_req_ready;
  assign w_dec_valid = (w_queue_count != 2'd0);
  assign w_pop       = w_dec_valid && !i_stall;

  // A request is still in flight past this edge if it was just accepted or its response has not arrived.
  assign w_outstanding = w_hs ||
                         (((r_state == ST_WAIT) || (r_state == ST_DROP)) && !i_imem_rsp_valid);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_push       = 1'b0;

    case (r_state)
      ST_REQ: begin
        if (w_hs) begin
          w_state_nxt  = ST_WAIT;
          w_pc_nxt     = r_pc + PC_STEP;
          w_req_pc_nxt = r_pc;
        end
      end
      ST_WAIT: begin
        if (i_imem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (i_imem_rsp_valid) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase

    if (i_redirect_valid) begin
      w_push      = 1'b0;
      w_pc_nxt    = align_pc(i_redirect_pc);
      w_state_nxt = w_outstanding ? ST_DROP : ST_REQ;
    end
  end

  always_comb begin
    w_count_nxt = w_queue_count + {1'b0, w_push} - {1'b0, w_pop};
    if (i_redirect_valid) w_count_nxt = 2'd0;
    w_req_valid_nxt = (w_state_nxt == ST_REQ) && (w_count_nxt <= 2'd1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
    end
  end

  zacore_fetch_queue u_queue (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_pc   (r_req_pc),
    .i_push_inst (i_imem_rsp_data),
    .i_pop       (w_pop),
    .i_flush     (i_redirect_valid),
    .o_head_pc   (w_head_pc),
    .o_head_inst (w_head_inst),
    .o_count     (w_queue_count)
  );

  assign o_imem_req_valid        = r_req_valid;
  assign o_imem_req_addr         = r_pc;
  assign o_fetch_decode_if.valid = w_dec_valid;
  assign o_fetch_decode_if.pc    = w_head_pc;
  assign o_fetch_decode_if.inst  = w_head_inst;

endmodule
